glitch_filter: RTL and testbench

GLITCH_FILTER -- requirements
Module: glitch_filter

---
 rtl/glitch_filter_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/glitch_filter.sv | 115 +++++++++++
 tb/tb_glitch_filter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_filter_pkg.sv
// Shared types and constants for the glitch filter: FSM encoding, default
// parameter values and the run-counter width.
package glitch_filter_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int STABLE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 8;
  localparam int RUN_W             = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, clearable by rst.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule

// File: rtl/glitch_filter.sv
// Debounces an asynchronous level: a change is accepted only after
// STABLE_CYCLES consecutive differing samples; shorter runs are counted as glitches.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [RUN_W-1:0] glitch_len,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam logic [RUN_W-1:0] LAST = RUN_W'(STABLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             sync2;
  state_t           state, state_n;
  logic [RUN_W-1:0] run_cnt, run_n;
  logic             dout_n, rise_n, fall_n, glitch_n;
  logic [RUN_W-1:0] glen_n;
  logic [CNT_W-1:0] gcnt_n;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (sync2)
  );

  always_comb begin
    state_n  = state;
    run_n    = run_cnt;
    dout_n   = dout;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    glitch_n = 1'b0;
    glen_n   = glitch_len;
    gcnt_n   = glitch_cnt;
    case (state)
      STABLE: begin
        run_n = '0;
        if (sync2 != dout) begin
          if (STABLE_CYCLES == 1) begin
            dout_n = sync2;
            rise_n = sync2;
            fall_n = ~sync2;
          end else begin
            state_n = PENDING;
            run_n   = RUN_W'(1);
          end
        end
      end
      PENDING: begin
        if (sync2 != dout) begin
          if (run_cnt == LAST) begin
            dout_n  = sync2;
            rise_n  = sync2;
            fall_n  = ~sync2;
            run_n   = '0;
            state_n = STABLE;
          end else begin
            run_n = run_cnt + RUN_W'(1);
          end
        end else begin
          // Level returned before the run qualified: report and drop it.
          glitch_n = 1'b1;
          glen_n   = run_cnt;
          gcnt_n   = sat_inc(glitch_cnt);
          run_n    = '0;
          state_n  = STABLE;
        end
      end
      default: begin
        state_n = STABLE;
        run_n   = '0;
      end
    endcase
    if (clr_cnt) gcnt_n = '0;
  end

  // Filter state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE;
      run_cnt    <= '0;
      dout       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch     <= 1'b0;
      glitch_len <= '0;
      glitch_cnt <= '0;
    end else begin
      state      <= state_n;
      run_cnt    <= run_n;
      dout       <= dout_n;
      rise       <= rise_n;
      fall       <= fall_n;
      glitch     <= glitch_n;
      glitch_len <= glen_n;
      glitch_cnt <= gcnt_n;
    end
  end

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter with a run-length reference model checked every cycle.
`timescale 1ns/1ps
module tb_glitch_filter;

  localparam int SC    = 4;
  localparam int CW    = 8;
  localparam int GMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          clr_cnt;
  logic          dout, rise, fall, glitch;
  logic [7:0]    glitch_len;
  logic [CW-1:0] glitch_cnt;

  int total = 0;
  int bad   = 0;

  glitch_filter #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .clr_cnt    (clr_cnt),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .glitch     (glitch),
    .glitch_len (glitch_len),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT on each rising edge.
  logic din_smp, rst_smp, clr_smp;
  int   edges = 0;
  always @(posedge clk) begin
    din_smp <= din;
    rst_smp <= rst;
    clr_smp <= clr_cnt;
    edges   <= edges + 1;
  end

  // Reference: din is seen two edges late; a run of SC differing samples flips
  // the level, a shorter run that ends is a glitch of that many samples.
  logic m_s1, m_s2, m_dout, m_rise, m_fall, m_glitch, s2_now;
  int   m_run, m_glen, m_gcnt;

  always @(negedge clk) begin
    if (edges > 0) begin
      m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
      if (rst_smp) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0;
        m_run = 0; m_glen = 0; m_gcnt = 0;
      end else begin
        s2_now = m_s2;
        m_s2   = m_s1;
        m_s1   = din_smp;
        if (s2_now != m_dout) begin
          m_run++;
          if (m_run == SC) begin
            m_dout = s2_now;
            m_rise = s2_now;
            m_fall = ~s2_now;
            m_run  = 0;
          end
        end else begin
          if (m_run > 0) begin
            m_glitch = 1'b1;
            m_glen   = m_run;
            if (m_gcnt < GMAX) m_gcnt++;
          end
          m_run = 0;
        end
        if (clr_smp) m_gcnt = 0;
      end
      check("model_dout", dout, m_dout);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_glitch", glitch, m_glitch);
      check("model_glitch_len", glitch_len, m_glen);
      check("model_glitch_cnt", glitch_cnt, m_gcnt);
    end
  end

  task automatic pulse_low(input int periods);
    @(negedge clk);
    din = 1'b0;
    #(10 * periods);
    din = 1'b1;
  endtask

  task automatic wait_glitch(output logic seen, output logic [7:0] len);
    seen = 1'b0;
    len  = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (glitch) begin
        seen = 1'b1;
        len  = glitch_len;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  logic       seen;
  logic [7:0] len;
  int         hits;

  initial begin
    rst = 1'b1; din = 1'b1; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 0);
    check("reset_cnt", glitch_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Rising level after reset release lands on the 6th edge.
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) check("release_dout_edge5", dout, 0);
    end
    @(posedge clk); #1;
    check("release_dout_edge6", dout, 1);
    check("release_rise_edge6", rise, 1);
    check("release_cnt", glitch_cnt, 0);
    @(posedge clk); #1;
    check("release_rise_edge7", rise, 0);

    // 20 ns low pulse: two samples, rejected.
    pulse_low(2);
    wait_glitch(seen, len);
    check("g20_seen", seen, 1);
    check("g20_len", len, 2);
    check("g20_cnt", glitch_cnt, 1);
    check("g20_dout", dout, 1);

    // Sub-period low pulses never sampled.
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2 din = 1'b0;
      #0.5 din = 1'b1;
      @(posedge clk); #1;
      if (rise || fall || glitch) hits++;
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (rise || fall || glitch) hits++;
    end
    check("subperiod_events", hits, 0);
    check("subperiod_dout", dout, 1);

    // Accepted fall, then a 3-sample high glitch, then accepted rise.
    @(negedge clk) din = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("fall_dout", dout, 0);
    @(negedge clk) din = 1'b1;
    #30 din = 1'b0;
    wait_glitch(seen, len);
    check("g30_seen", seen, 1);
    check("g30_len", len, 3);
    check("g30_cnt", glitch_cnt, 2);
    check("g30_dout", dout, 0);
    @(negedge clk) din = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rise_dout", dout, 1);

    // Saturation of the glitch counter.
    for (int i = 0; i < 300; i++) begin
      pulse_low(2);
      repeat (5) @(posedge clk);
    end
    #1;
    check("sat_cnt", glitch_cnt, GMAX);
    @(negedge clk) clr_cnt = 1'b1;
    @(negedge clk) clr_cnt = 1'b0;
    #1;
    check("clr_cnt", glitch_cnt, 0);

    // Clear on the same edge as a glitch: clear wins, pulse still fires.
    pulse_low(2);
    repeat (5) @(posedge clk);
    #1;
    check("pre_clr_cnt", glitch_cnt, 1);
    @(negedge clk) din = 1'b0;
    #20 din = 1'b1;
    #20 clr_cnt = 1'b1;
    @(posedge clk); #1;
    check("clr_same_glitch", glitch, 1);
    check("clr_same_cnt", glitch_cnt, 0);
    #4 clr_cnt = 1'b0;

    // Reset while pending with run_cnt = 2.
    repeat (3) @(posedge clk);
    @(negedge clk) din = 1'b0;
    #40 rst = 1'b1;
    @(posedge clk); #1;
    check("rstp_dout", dout, 0);
    check("rstp_glitch", glitch, 0);
    check("rstp_rise_fall", rise | fall, 0);
    check("rstp_len", glitch_len, 0);
    check("rstp_cnt", glitch_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    din = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("after_rst_dout", dout, 1);
    check("after_rst_cnt", glitch_cnt, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
